motor_pwm_drv: RTL and testbench
================================

MOTOR_PWM_DRV -- requirements
Module: motor_pwm_drv

Interface
REQ-001 SHALL have parameter PRESC, default 4: clk cycles per PWM tick (range 1..255).
REQ-002 SHALL have parameter DUTY_MAX, default 192: full-run duty, 8-bit.
REQ-003 SHALL have parameter RAMP_STEP, default 32: duty increment per PWM period.
REQ-004 SHALL have parameter DEAD_CYC, default 16: clk cycles with both bridge pins low on reversal.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have ports md1, md2, input, 1 each: left motor command; {md1,md2}=10 FWD, 01 REV, 00 COAST.
REQ-008 SHALL have ports md3, md4, input, 1 each: right motor command, same encoding.
REQ-009 SHALL have ports pwm_l_a, pwm_l_b, output, 1 each: left H-bridge pins (a = forward, b = reverse).
REQ-010 SHALL have ports pwm_r_a, pwm_r_b, output, 1 each: right H-bridge pins.
REQ-011 SHALL have ports run_l, run_r, output, 1 each: channel in RUN state.

Function
REQ-012 SHALL generate a shared prescaler counting 0..PRESC-1; tick when it equals PRESC-1.
REQ-013 SHALL have a shared 8-bit pwm_cnt that increments on tick and wraps 255->0; "wrap" is tick with pwm_cnt==255.
REQ-014 SHALL decode command 11 as COAST.
REQ-015 SHALL give each channel states IDLE, RAMP, RUN, DEAD, plus a latched direction and an 8-bit duty.
REQ-016 SHALL drive the active pin = (pwm_cnt < duty) and the inactive pin 0 in RAMP/RUN; both pins 0 in IDLE/DEAD.
REQ-017 SHALL register all outputs, giving 1 clk latency from compare/state to pin.
REQ-018 IDLE, cmd FWD/REV: SHALL go to RAMP, latch dir, duty=min(RAMP_STEP,DUTY_MAX).
REQ-019 RAMP, on wrap: duty=min(duty+RAMP_STEP, DUTY_MAX), saturating with no 8-bit overflow; SHALL go to RUN when the result equals DUTY_MAX.
REQ-020 RUN: duty SHALL hold at DUTY_MAX.
REQ-021 RAMP/RUN, cmd COAST: SHALL go to IDLE next cycle with duty=0.
REQ-022 RAMP/RUN, cmd opposite dir: SHALL go to DEAD, duty=0, load dead counter with DEAD_CYC.
REQ-023 DEAD: SHALL decrement each clk; at expiry sample cmd: FWD/REV -> RAMP with that dir (REQ-018 duty); COAST -> IDLE.
REQ-024 A same-dir cmd in RAMP/RUN SHALL cause no change.
REQ-025 A cmd change in the same cycle as a wrap SHALL take priority over the duty increment.
REQ-026 Both pins of one channel SHALL never be high in the same cycle.

Reset
REQ-027 While reset is high: all six outputs 0, both channels IDLE, duty 0, prescaler/pwm_cnt/dead counters 0, applied asynchronously including mid-RAMP/RUN/DEAD.
REQ-028 After reset release: the first rising edge SHALL evaluate commands normally.

Configuration
REQ-029 Macro MOTOR_PWM_SOFTSTART_EN defined: ramp behaviour per REQ-018/019.
REQ-030 Macro MOTOR_PWM_SOFTSTART_EN undefined: RAMP state absent; IDLE/DEAD exits go directly to RUN with duty=DUTY_MAX; RAMP_STEP ignored.

Structure
REQ-031 Package motor_pkg SHALL hold the channel state enum, the direction/command encoding constants (FWD, REV, COAST), and parameter defaults.
REQ-032 Sub-module motor_chan (one motor FSM, duty, dead counter, pin drive) SHALL be instantiated twice; prescaler and pwm_cnt SHALL stay in motor_pwm_drv.

Verification
REQ-033 Reset asserted mid-RUN: all outputs 0 before next clk edge; run_l=run_r=0.
REQ-034 Softstart on, md=1010 from IDLE: pwm_l_a and pwm_r_a high-time per 1024-clk period = 128,256,384,512,640,768 clk; run_l/run_r rise after 5th wrap; *_b stay 0.
REQ-035 Left RUN FWD, then md1md2=01: pwm_l_a/b both 0 for exactly 16 clk, then pwm_l_b high 128 clk in first period; right channel unaffected.
REQ-036 Softstart off, md=1010: run_l=1 one clk after the command, pwm_l_a high 768 of each 1024 clk.
REQ-037 md1md2=11 from RUN: channel to IDLE, pins 0; COAST during DEAD: IDLE at expiry, no pulse.
REQ-038 Reversal command in the same cycle as a wrap during RAMP: DEAD entered, duty not incremented, no both-high cycle.

Source files
------------

// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - channel state enum, command encodings and defaults for motor_pwm_drv
package motor_pkg;

    localparam int PRESC_DEF     = 4;
    localparam int DUTY_MAX_DEF  = 192;
    localparam int RAMP_STEP_DEF = 32;
    localparam int DEAD_CYC_DEF  = 16;

    // {mdA,mdB} command codes; 11 is decoded as COAST by the channel
    localparam logic [1:0] FWD   = 2'b10;
    localparam logic [1:0] REV   = 2'b01;
    localparam logic [1:0] COAST = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2,
        ST_DEAD = 2'd3
    } chan_state_e;

    // min(a + b, lim) computed in 9 bits so the 8-bit duty never wraps
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] lim);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= {1'b0, lim}) ? lim : sum[7:0];
    endfunction

endpackage

// File: rtl/motor_pwm_drv_if.sv
// rtl/motor_pwm_drv_if.sv - per-channel command / bridge-pin bundle
interface motor_pwm_drv_if;
    logic [1:0] cmd;
    logic       pin_a;
    logic       pin_b;
    logic       run;

    modport master (output cmd, input pin_a, input pin_b, input run);
    modport slave  (input cmd, output pin_a, output pin_b, output run);
endinterface

// File: rtl/motor_chan.sv
// rtl/motor_chan.sv - one H-bridge channel FSM, duty, dead counter and pin drive (MOTOR_PWM_SOFTSTART_EN enables ramp)
module motor_chan
    import motor_pkg::*;
#(
    parameter int DUTY_MAX  = DUTY_MAX_DEF,
    parameter int RAMP_STEP = RAMP_STEP_DEF,
    parameter int DEAD_CYC  = DEAD_CYC_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     pwm_cnt_i,
`ifdef MOTOR_PWM_SOFTSTART_EN
    input  logic           wrap_i,
`endif
    motor_pwm_drv_if.slave chan_if
);

    localparam logic [7:0] DMAX = 8'(DUTY_MAX);
    localparam logic [7:0] STEP = 8'(RAMP_STEP);
    localparam logic [7:0] DEAD = 8'(DEAD_CYC);
`ifdef MOTOR_PWM_SOFTSTART_EN
    localparam chan_state_e START_ST   = ST_RAMP;
    localparam logic [7:0]  START_DUTY = sat_add(8'd0, STEP, DMAX);
`else
    // Without soft start the single step saturates straight to full duty
    localparam chan_state_e START_ST   = ST_RUN;
    localparam logic [7:0]  START_DUTY = sat_add(DMAX, STEP, DMAX);
`endif

    chan_state_e state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic [7:0]  duty_q, duty_d;
    logic [7:0]  dead_q, dead_d;
    logic        pin_a_q, pin_b_q, run_q;
    logic        cmd_move;
    logic        active;

    assign cmd_move = (chan_if.cmd == FWD) || (chan_if.cmd == REV);
    assign active   = ((state_q == ST_RAMP) || (state_q == ST_RUN)) && (pwm_cnt_i < duty_q);

    // Next state: command changes win over the ramp increment on a wrap
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        duty_d  = duty_q;
        dead_d  = dead_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_move) begin
                    state_d = START_ST;
                    dir_d   = chan_if.cmd;
                    duty_d  = START_DUTY;
                end
            end
            ST_DEAD: begin
                dead_d = (dead_q != 8'd0) ? dead_q - 8'd1 : 8'd0;
                if (dead_q <= 8'd1) begin
                    if (cmd_move) begin
                        state_d = START_ST;
                        dir_d   = chan_if.cmd;
                        duty_d  = START_DUTY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                if (!cmd_move) begin
                    state_d = ST_IDLE;
                    duty_d  = 8'd0;
                end else if (chan_if.cmd != dir_q) begin
                    state_d = ST_DEAD;
                    duty_d  = 8'd0;
                    dead_d  = DEAD;
                end
`ifdef MOTOR_PWM_SOFTSTART_EN
                else if ((state_q == ST_RAMP) && wrap_i) begin
                    duty_d = sat_add(duty_q, STEP, DMAX);
                    if (duty_d == DMAX) begin
                        state_d = ST_RUN;
                    end
                end
`endif
            end
        endcase
    end

    // Channel state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dir_q   <= COAST;
            duty_q  <= 8'd0;
            dead_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            duty_q  <= duty_d;
            dead_q  <= dead_d;
        end
    end

    // Registered pins: only the pin matching the latched direction can be driven
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pin_a_q <= 1'b0;
            pin_b_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            pin_a_q <= active && (dir_q == FWD);
            pin_b_q <= active && (dir_q == REV);
            run_q   <= (state_d == ST_RUN);
        end
    end

    assign chan_if.pin_a = pin_a_q;
    assign chan_if.pin_b = pin_b_q;
    assign chan_if.run   = run_q;

endmodule

// File: rtl/motor_pwm_drv.sv
// rtl/motor_pwm_drv.sv - dual H-bridge PWM driver top, shared prescaler/pwm counter (MOTOR_PWM_SOFTSTART_EN enables ramp)
module motor_pwm_drv
    import motor_pkg::*;
#(
    parameter int PRESC     = PRESC_DEF,
    parameter int DUTY_MAX  = DUTY_MAX_DEF,
    parameter int RAMP_STEP = RAMP_STEP_DEF,
    parameter int DEAD_CYC  = DEAD_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md1,
    input  logic md2,
    input  logic md3,
    input  logic md4,
    output logic pwm_l_a,
    output logic pwm_l_b,
    output logic pwm_r_a,
    output logic pwm_r_b,
    output logic run_l,
    output logic run_r
);

    localparam logic [7:0] PRESC_LAST = 8'(PRESC - 1);

    logic [7:0] presc_q, presc_d;
    logic [7:0] pwm_cnt_q, pwm_cnt_d;
    logic       tick;

    assign tick = (presc_q == PRESC_LAST);

    // Prescaler and 8-bit PWM counter; pwm_cnt wraps 255->0 naturally
    always_comb begin
        presc_d   = tick ? 8'd0 : presc_q + 8'd1;
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    end

    // Shared timebase registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= 8'd0;
            pwm_cnt_q <= 8'd0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

`ifdef MOTOR_PWM_SOFTSTART_EN
    logic wrap;
    assign wrap = tick && (pwm_cnt_q == 8'hFF);
`endif

    motor_pwm_drv_if l_if ();
    motor_pwm_drv_if r_if ();

    assign l_if.cmd = {md1, md2};
    assign r_if.cmd = {md3, md4};

    motor_chan #(
        .DUTY_MAX  (DUTY_MAX),
        .RAMP_STEP (RAMP_STEP),
        .DEAD_CYC  (DEAD_CYC)
    ) u_chan_l (
        .clk       (clk),
        .reset     (reset),
        .pwm_cnt_i (pwm_cnt_q),
`ifdef MOTOR_PWM_SOFTSTART_EN
        .wrap_i    (wrap),
`endif
        .chan_if   (l_if)
    );

    motor_chan #(
        .DUTY_MAX  (DUTY_MAX),
        .RAMP_STEP (RAMP_STEP),
        .DEAD_CYC  (DEAD_CYC)
    ) u_chan_r (
        .clk       (clk),
        .reset     (reset),
        .pwm_cnt_i (pwm_cnt_q),
`ifdef MOTOR_PWM_SOFTSTART_EN
        .wrap_i    (wrap),
`endif
        .chan_if   (r_if)
    );

    assign pwm_l_a = l_if.pin_a;
    assign pwm_l_b = l_if.pin_b;
    assign run_l   = l_if.run;
    assign pwm_r_a = r_if.pin_a;
    assign pwm_r_b = r_if.pin_b;
    assign run_r   = r_if.run;

endmodule

// File: tb/tb_motor_pwm_drv.sv
// tb/tb_motor_pwm_drv.sv - randomized self-checking bench for motor_pwm_drv (honours MOTOR_PWM_SOFTSTART_EN)
module tb_motor_pwm_drv;

    localparam int PRESC     = 4;
    localparam int DUTY_MAX  = 192;
    localparam int RAMP_STEP = 32;
    localparam int DEAD_CYC  = 16;
    localparam int PERIOD    = PRESC * 256;

    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_RUN  = 2;
    localparam int M_DEAD = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    motor_pwm_drv_if l_if ();
    motor_pwm_drv_if r_if ();

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: time since release plus per-channel mode/dir/duty/dead
    int   m_t;
    int   m_mode [2];
    int   m_dir  [2];
    int   m_duty [2];
    int   m_dead [2];
    logic m_a    [2];
    logic m_b    [2];
    logic m_run  [2];

    always #5 clk = ~clk;

    motor_pwm_drv #(
        .PRESC     (PRESC),
        .DUTY_MAX  (DUTY_MAX),
        .RAMP_STEP (RAMP_STEP),
        .DEAD_CYC  (DEAD_CYC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .md1     (l_if.cmd[1]),
        .md2     (l_if.cmd[0]),
        .md3     (r_if.cmd[1]),
        .md4     (r_if.cmd[0]),
        .pwm_l_a (l_if.pin_a),
        .pwm_l_b (l_if.pin_b),
        .pwm_r_a (r_if.pin_a),
        .pwm_r_b (r_if.pin_b),
        .run_l   (l_if.run),
        .run_r   (r_if.run)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int all_outs();
        return {26'd0, l_if.pin_a, l_if.pin_b, l_if.run, r_if.pin_a, r_if.pin_b, r_if.run};
    endfunction

    function automatic int dec_cmd(input logic [1:0] c);
        if (c == 2'b10) return 1;
        if (c == 2'b01) return -1;
        return 0;
    endfunction

    function automatic int exp_hi(input int p);
        int d;
        d = RAMP_STEP * (p + 1);
`ifdef MOTOR_PWM_SOFTSTART_EN
        if (d > DUTY_MAX) d = DUTY_MAX;
`else
        d = DUTY_MAX;
`endif
        return d * PRESC;
    endfunction

    task automatic model_reset();
        m_t = 0;
        for (int ch = 0; ch < 2; ch++) begin
            m_mode[ch] = M_IDLE;
            m_dir[ch]  = 0;
            m_duty[ch] = 0;
            m_dead[ch] = 0;
            m_a[ch]    = 1'b0;
            m_b[ch]    = 1'b0;
            m_run[ch]  = 1'b0;
        end
    endtask

    task automatic model_start(input int ch, input int c);
        m_dir[ch] = c;
`ifdef MOTOR_PWM_SOFTSTART_EN
        m_mode[ch] = M_RAMP;
        m_duty[ch] = (RAMP_STEP < DUTY_MAX) ? RAMP_STEP : DUTY_MAX;
`else
        m_mode[ch] = M_RUN;
        m_duty[ch] = DUTY_MAX;
`endif
    endtask

    task automatic model_edge();
        int  pwm;
        bit  wrap;
        int  c;
        bit  on;
        pwm  = (m_t / PRESC) % 256;
        wrap = (m_t % PERIOD) == (PERIOD - 1);
        for (int ch = 0; ch < 2; ch++) begin
            c  = dec_cmd(ch == 0 ? l_if.cmd : r_if.cmd);
            on = ((m_mode[ch] == M_RAMP) || (m_mode[ch] == M_RUN)) && (pwm < m_duty[ch]);
            m_a[ch] = on && (m_dir[ch] > 0);
            m_b[ch] = on && (m_dir[ch] < 0);
            case (m_mode[ch])
                M_IDLE: if (c != 0) model_start(ch, c);
                M_DEAD: begin
                    m_dead[ch]--;
                    if (m_dead[ch] <= 0) begin
                        if (c != 0) model_start(ch, c);
                        else m_mode[ch] = M_IDLE;
                    end
                end
                default: begin
                    if (c == 0) begin
                        m_mode[ch] = M_IDLE;
                        m_duty[ch] = 0;
                    end else if (c != m_dir[ch]) begin
                        m_mode[ch] = M_DEAD;
                        m_duty[ch] = 0;
                        m_dead[ch] = DEAD_CYC;
                    end else if ((m_mode[ch] == M_RAMP) && wrap) begin
                        m_duty[ch] = m_duty[ch] + RAMP_STEP;
                        if (m_duty[ch] >= DUTY_MAX) begin
                            m_duty[ch] = DUTY_MAX;
                            m_mode[ch] = M_RUN;
                        end
                    end
                end
            endcase
            m_run[ch] = (m_mode[ch] == M_RUN);
        end
        m_t++;
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("chan_l", {29'd0, l_if.pin_a, l_if.pin_b, l_if.run}, {29'd0, m_a[0], m_b[0], m_run[0]});
        check("chan_r", {29'd0, r_if.pin_a, r_if.pin_b, r_if.run}, {29'd0, m_a[1], m_b[1], m_run[1]});
        check("no_shoot", {30'd0, l_if.pin_a & l_if.pin_b, r_if.pin_a & r_if.pin_b}, 0);
    endtask

    task automatic wait_phase(input int ph);
        for (int n = 0; n < 2 * PERIOD; n++) begin
            if ((m_t % PERIOD) == ph) break;
            tick_cycle();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_l;
        int hi_r;
        int gap;
        int nper;
        l_if.cmd = 2'b00;
        r_if.cmd = 2'b00;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 0);

        // both channels forward from IDLE; per-period high time
        l_if.cmd = 2'b10;
        r_if.cmd = 2'b10;
        reset = 1'b0;
`ifdef MOTOR_PWM_SOFTSTART_EN
        nper = 6;
`else
        nper = 3;
`endif
        for (int p = 0; p < nper; p++) begin
            hi_l = 0;
            hi_r = 0;
            for (int i = 0; i < PERIOD; i++) begin
                tick_cycle();
                hi_l += int'(l_if.pin_a);
                hi_r += int'(r_if.pin_a);
                if (p == 0 && i == 0) begin
`ifdef MOTOR_PWM_SOFTSTART_EN
                    check("run_l_first_clk", int'(l_if.run), 0);
`else
                    check("run_l_first_clk", int'(l_if.run), 1);
`endif
                end
            end
            if (p >= 1) begin
                check("hi_time_l", hi_l, exp_hi(p));
                check("hi_time_r", hi_r, exp_hi(p));
            end
        end

        // reversal on the left: dead gap length
        wait_phase(32);
        l_if.cmd = 2'b01;
        tick_cycle();
        gap = 0;
        for (int i = 0; i < 100; i++) begin
            tick_cycle();
            if (l_if.pin_b) break;
            if (!l_if.pin_a) gap++;
        end
        check("dead_gap", gap, DEAD_CYC);
        check("right_still_run", int'(r_if.run), 1);

        // command 11 decodes as coast
        l_if.cmd = 2'b11;
        repeat (3) tick_cycle();
        check("coast_11", {29'd0, l_if.pin_a, l_if.pin_b, l_if.run}, 0);

        // coast issued while in DEAD: no pulse afterwards
        l_if.cmd = 2'b10;
        repeat (PERIOD + 50) tick_cycle();
        l_if.cmd = 2'b01;
        repeat (5) tick_cycle();
        l_if.cmd = 2'b00;
        hi_l = 0;
        for (int i = 0; i < 40; i++) begin
            tick_cycle();
            hi_l += int'(l_if.pin_a | l_if.pin_b);
        end
        check("dead_coast_quiet", hi_l, 0);

        // reversal presented exactly on a wrap edge
        r_if.cmd = 2'b00;
        repeat (2) tick_cycle();
        r_if.cmd = 2'b01;
        tick_cycle();
        wait_phase(PERIOD - 1);
        r_if.cmd = 2'b10;
        repeat (31) tick_cycle();
`ifdef MOTOR_PWM_SOFTSTART_EN
        check("wrap_rev_run", int'(r_if.run), 0);
`else
        check("wrap_rev_run", int'(r_if.run), 1);
`endif

        // random command traffic
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 199) == 0) l_if.cmd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) r_if.cmd = 2'($urandom_range(0, 3));
            tick_cycle();
        end

        // asynchronous reset in the middle of running
        l_if.cmd = 2'b10;
        r_if.cmd = 2'b10;
        repeat (1200) tick_cycle();
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset", all_outs(), 0);
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_hold", all_outs(), 0);
        l_if.cmd = 2'b01;
        r_if.cmd = 2'b10;
        reset = 1'b0;
        repeat (60) tick_cycle();
`ifdef MOTOR_PWM_SOFTSTART_EN
        check("post_reset_run_l", int'(l_if.run), 0);
`else
        check("post_reset_run_l", int'(l_if.run), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
